// File: rtl/alu_mul_sequencer_pkg.sv
// Shared ALUCtrl codes, FSM state encodings and the MUL trigger predicate
// for the EX-stage multiply sequencer.
package alu_mul_sequencer_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_LUI = 4'b1001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic logic mul_hit(input logic valid, input logic [3:0] ctrl,
                                   input logic [3:0] code, input logic flush);
    return valid & (ctrl == code) & ~flush;
  endfunction

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// EX-stage request/response bundle between the pipeline and the multiply sequencer.
interface alu_mul_sequencer_if #(
  parameter int DATA_W = 32
);
  logic              valid_i;
  logic [3:0]        alu_ctrl_i;
  logic [DATA_W-1:0] src1_i;
  logic [DATA_W-1:0] src2_i;
  logic              flush_i;
  logic              stall_o;
  logic              busy_o;
  logic              done_o;
  logic [DATA_W-1:0] result_o;

  modport master (
    output valid_i, alu_ctrl_i, src1_i, src2_i, flush_i,
    input  stall_o, busy_o, done_o, result_o
  );

  modport slave (
    input  valid_i, alu_ctrl_i, src1_i, src2_i, flush_i,
    output stall_o, busy_o, done_o, result_o
  );
endinterface

// File: rtl/shift_add_mul_dp.sv
// Radix-2 shift-add multiply datapath: multiplicand, multiplier and accumulator
// registers, stepped one multiplier bit per cycle by the sequencer FSM.
module shift_add_mul_dp
  import alu_mul_sequencer_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic [DATA_W-1:0] acc_next
);
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;

  // Partial sum for the current multiplier bit; wraps mod 2^DATA_W.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= src1;
      mplier <= src2;
      acc    <= '0;
    end else if (step) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
endmodule

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle MUL sequencer beside the EX-stage ALU: stalls the pipeline for
// DATA_W+1 cycles, then pulses done with the low DATA_W bits of the product.
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int         DATA_W   = 32,
  parameter logic [3:0] MUL_CODE = ALU_MUL
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  alu_mul_sequencer_if.slave    bus
);
  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [CNT_W-1:0]  cnt;
  logic              hit;
  logic              load;
  logic              step;
  logic              last;
  logic              done;
  logic [DATA_W-1:0] acc_next;
  logic [DATA_W-1:0] result;

  assign hit  = mul_hit(bus.valid_i, bus.alu_ctrl_i, MUL_CODE, bus.flush_i);
  assign load = (state == ST_IDLE) & hit;
  assign step = (state == ST_RUN) & ~bus.flush_i;
  assign last = step & (cnt == CNT_LAST);

  shift_add_mul_dp #(.DATA_W(DATA_W)) u_dp (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (load),
    .step     (step),
    .src1     (bus.src1_i),
    .src2     (bus.src2_i),
    .acc_next (acc_next)
  );

  // DONE ignores the request inputs: the finished MUL is still sitting in EX.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (load) state_next = ST_RUN;
      ST_RUN: begin
        if (bus.flush_i) state_next = ST_IDLE;
        else if (last)   state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      state <= state_next;
      done  <= last;
      if (last) result <= acc_next;
      if (load)                        cnt <= '0;
      else if (step && !last)          cnt <= cnt + 1'b1;
    end
  end

  // Stall is held low during reset even if a MUL is presented.
  assign bus.stall_o  = rst_i & (load | step);
  assign bus.busy_o   = (state != ST_IDLE);
  assign bus.done_o   = done;
  assign bus.result_o = result;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed self-checking bench for alu_mul_sequencer.
module tb_alu_mul_sequencer;
  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fails  = 0;

  alu_mul_sequencer_if #(.DATA_W(32)) bus ();

  alu_mul_sequencer #(.DATA_W(32), .MUL_CODE(4'b0011)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b);
    bus.valid_i    = v;
    bus.alu_ctrl_i = c;
    bus.src1_i     = a;
    bus.src2_i     = b;
    bus.flush_i    = 1'b0;
  endtask

  // Issue a MUL at the current negedge and follow it to the DONE cycle.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expv, input string tag);
    int n;
    int d;
    drive(1'b1, 4'b0011, a, b);
    #1;
    chk({tag, " issue_stall"}, 32'(bus.stall_o), 32'd1);
    chk({tag, " issue_busy"}, 32'(bus.busy_o), 32'd0);
    n = 0;
    d = 0;
    while (bus.stall_o === 1'b1 && n < 40) begin
      n++;
      if (bus.done_o === 1'b1) d++;
      @(negedge clk);
    end
    chk({tag, " stall_cycles"}, 32'(n), 32'd33);
    chk({tag, " early_done"}, 32'(d), 32'd0);
    chk({tag, " done"}, 32'(bus.done_o), 32'd1);
    chk({tag, " result"}, bus.result_o, expv);
  endtask

  initial begin
    int d;
    rst_n = 1'b0;
    drive(1'b0, 4'b0000, 32'd0, 32'd0);
    #1;
    chk("rst stall", 32'(bus.stall_o), 32'd0);
    chk("rst busy", 32'(bus.busy_o), 32'd0);
    chk("rst done", 32'(bus.done_o), 32'd0);
    chk("rst result", bus.result_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst busy", 32'(bus.busy_o), 32'd0);

    // Basic multiply and single-cycle done pulse
    do_mul(32'd7, 32'd6, 32'd42, "mul7x6");
    bus.valid_i = 1'b0;
    @(negedge clk);
    chk("mul7x6 done_drop", 32'(bus.done_o), 32'd0);
    chk("mul7x6 idle", 32'(bus.busy_o), 32'd0);
    chk("mul7x6 hold", bus.result_o, 32'd42);

    // Signed operands: low bits match unsigned product
    do_mul(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, "neg3x5");
    bus.valid_i = 1'b0;
    @(negedge clk);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, "m1xm1");
    bus.valid_i = 1'b0;
    @(negedge clk);

    // Back-to-back: second MUL issued in the first IDLE cycle after DONE
    do_mul(32'd3, 32'd4, 32'd12, "b2b_a");
    @(negedge clk);
    chk("b2b gap_done", 32'(bus.done_o), 32'd0);
    chk("b2b gap_busy", 32'(bus.busy_o), 32'd0);
    do_mul(32'd5, 32'd5, 32'd25, "b2b_b");
    bus.valid_i = 1'b0;
    @(negedge clk);
    chk("b2b done_drop", 32'(bus.done_o), 32'd0);

    // Flush in RUN at cnt=10
    drive(1'b1, 4'b0011, 32'd9, 32'd9);
    repeat (11) @(negedge clk);
    chk("flush pre_stall", 32'(bus.stall_o), 32'd1);
    bus.flush_i = 1'b1;
    #1;
    chk("flush stall_gate", 32'(bus.stall_o), 32'd0);
    chk("flush busy", 32'(bus.busy_o), 32'd1);
    @(negedge clk);
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    #1;
    chk("flush idle", 32'(bus.busy_o), 32'd0);
    chk("flush result_kept", bus.result_o, 32'd25);
    d = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) d++;
    end
    chk("flush no_done", 32'(d), 32'd0);
    chk("flush result_still", bus.result_o, 32'd25);

    // Non-MUL codes and invalid MUL are ignored
    drive(1'b1, 4'b0010, 32'd7, 32'd6);
    #1;
    chk("add stall", 32'(bus.stall_o), 32'd0);
    d = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.stall_o !== 1'b0) d++;
    end
    chk("add quiet", 32'(d), 32'd0);
    drive(1'b0, 4'b0011, 32'd7, 32'd6);
    #1;
    chk("novalid stall", 32'(bus.stall_o), 32'd0);
    d = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.stall_o !== 1'b0) d++;
    end
    chk("novalid quiet", 32'(d), 32'd0);

    // Asynchronous reset mid-operation
    drive(1'b1, 4'b0011, 32'd7, 32'd6);
    repeat (5) @(negedge clk);
    chk("midrst busy_before", 32'(bus.busy_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst stall", 32'(bus.stall_o), 32'd0);
    chk("midrst busy", 32'(bus.busy_o), 32'd0);
    chk("midrst done", 32'(bus.done_o), 32'd0);
    chk("midrst result", bus.result_o, 32'd0);
    @(negedge clk);
    bus.valid_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst idle", 32'(bus.busy_o), 32'd0);
    chk("midrst nodone", 32'(bus.done_o), 32'd0);
    do_mul(32'd7, 32'd6, 32'd42, "after_rst");
    bus.valid_i = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
